muldiv_iter: RTL
================

Name: muldiv_iter

Overview:
Parametrised iterative RV32M/RV64M multiply/divide unit. It is the successor to the fixed-width MULDIV in the core pipeline. It sits beside EX: it accepts one operation per request handshake, iterates internally, and returns the result with a tag. It adds configurable XLEN and multiply radix, single-cycle special-case fast paths, back-to-back issue, and a flush input driven by CTRL.

Parameters:
XLEN, 32, operand/result width; 32 or 64.
MUL_STEP, 1, multiplier bits retired per CALC cycle; power of 2 in {1,2,4,8}; must divide XLEN.
TAG_W, 5, width of opaque tag (rd address) carried from request to result.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous reset, active-low.
flush_i  in  1  abort the current op and drop any same-cycle request.
req_valid_i  in  1  request valid.
funct3_i  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
op_1_i  in  XLEN  rs1 operand.
op_2_i  in  XLEN  rs2 operand.
tag_i  in  TAG_W  request tag.
ready_o  out  1  unit can accept a request this cycle.
valid_o  out  1  result_o/tag_o valid this cycle (one-cycle pulse).
result_o  out  XLEN  result.
tag_o  out  TAG_W  tag of the completed op.
busy_o  out  1  state is CALC or FIXUP.

Behaviour:
- Reset (rst=0, async): state IDLE; ready_o=1; valid_o=0, busy_o=0, result_o=0, tag_o=0; all internal registers cleared. Reset mid-operation discards the op; no valid_o is produced.
- States: IDLE, CALC, FIXUP, DONE.
- ready_o = (state==IDLE || state==DONE) && !flush_i. A request is accepted when req_valid_i && ready_o. Operands, funct3 and tag are registered at acceptance; inputs are ignored after that.
- Operand signs:
  - MULH and DIV/REM treat both operands as signed.
  - MULHSU treats op_1 as signed and op_2 as unsigned.
  - All others are unsigned.
- Computation runs on magnitudes; sign is corrected in FIXUP.
- Accept path, normal: the next state is CALC with the iteration counter = N-1.
  - N = XLEN/MUL_STEP for multiplies.
  - N = XLEN for divides (restoring, 1 quotient bit per cycle).
- Accept path, fast (divides only): the next state is DONE with the result written directly.
  - Divide by zero (op_2==0): DIV/DIVU return all-ones; REM/REMU return op_1.
  - Signed overflow (DIV/REM with op_1 = 1<<(XLEN-1) and op_2 = all-ones): DIV returns op_1; REM returns 0.
- CALC:
  - Multiply: a 2*XLEN product accumulator does shift-add of MUL_STEP bits per cycle.
  - Divide: a restoring shift-subtract with an XLEN remainder and XLEN quotient.
  - The counter decrements each cycle; when it reaches 0 the next state is FIXUP.
- FIXUP (1 cycle):
  - Negate the product if the operand signs differ.
  - Negate the quotient if the signs differ (DIV). The remainder takes the sign of op_1 (REM).
  - Select the result: MUL gives the low XLEN bits; MULH/MULHSU/MULHU give the high XLEN bits.
  - Next state is DONE.
- DONE: valid_o=1 for exactly this cycle, with result_o and tag_o.
  - Next state is CALC (or DONE via the fast path) if a new request is accepted in this cycle; otherwise IDLE.
  - result_o/tag_o hold their values after DONE until the next completion.
- Latency from the acceptance edge to the valid_o cycle:
  - Normal ops: N+2 cycles (mul with XLEN=32, MUL_STEP=1: 34; MUL_STEP=4: 10; div: 34).
  - Fast path: 1 cycle.
- Throughput: one op per N+2 cycles with back-to-back issue (acceptance in DONE).
- Flush:
  - flush_i=1 in any state: next state is IDLE; valid_o=0 on the following edge. If flush_i is asserted in DONE, valid_o in that same cycle still stands (the op completed).
  - Flush together with req_valid_i: the request is not accepted (ready_o=0).
- The counter width is clog2(XLEN). No wrap past 0; the counter is only loaded at acceptance.

Test Plan:
- XLEN=32, MUL_STEP=1: MUL 7 × 0xFFFFFFFD, tag 5 → valid_o exactly 34 cycles after accept, result 0xFFFFFFEB, tag_o=5; ready_o=0 during CALC/FIXUP.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2; each at latency 34.
- Fast paths: DIVU 9/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0; each with valid_o 1 cycle after accept.
- Back-to-back: hold req_valid_i with MUL 3×4 then DIV 20/6 → second accepted in the DONE cycle of the first; results 12 then 3 with no idle cycle between.
- Flush at CALC cycle 10 → no valid_o, IDLE next cycle, then a new MUL 2×2 → 4. Separately, pulse rst low mid-CALC → all outputs 0 immediately and ready_o=1 after release. Rerun with MUL_STEP=4: MUL 7×3 → 21 at latency 10.

Source files
------------

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative RV32M/RV64M multiply/divide unit with tagged results
//
// Purpose: accepts one multiply or divide per request handshake. The operation
// iterates on operand magnitudes: shift-add multiply retiring MUL_STEP bits per
// cycle, or restoring divide retiring one quotient bit per cycle. A single FIXUP
// cycle then applies the sign. Divide-by-zero and signed overflow complete one
// cycle after acceptance.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   flush_i      abort the current op; a same-cycle request is refused
//   req_valid_i  request valid
//   funct3_i     RV M-extension funct3 (MUL..REMU)
//   op_1_i       rs1 operand
//   op_2_i       rs2 operand
//   tag_i        opaque tag returned with the result
//   ready_o      unit can accept a request this cycle
//   valid_o      one-cycle result pulse
//   result_o     result, held until the next completion
//   tag_o        tag of the completed op, held like result_o
//   busy_o       iterating or fixing up the sign
module muldiv_iter #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1,
  parameter int TAG_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             req_valid_i,
  input  logic [2:0]       funct3_i,
  input  logic [XLEN-1:0]  op_1_i,
  input  logic [XLEN-1:0]  op_2_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             busy_o
);

  localparam int              CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   MUL_LAST = CW'(XLEN / MUL_STEP - 1);
  localparam logic [CW-1:0]   DIV_LAST = CW'(XLEN - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIXUP,
    S_DONE
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  // Multiply: {product high, multiplier being consumed}.
  // Divide:   {partial remainder, dividend shifting into quotient}.
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   op_mag;     // multiplicand or divisor magnitude
  logic [2:0]        f3;
  logic [TAG_W-1:0]  tag_q;
  logic              neg_q;      // product or quotient must be negated
  logic              neg_r;      // remainder must be negated (dividend negative)

  logic accept;

  assign ready_o = ((state == S_IDLE) || (state == S_DONE)) && !flush_i;
  assign accept  = req_valid_i && ready_o;
  assign busy_o  = (state == S_CALC) || (state == S_FIXUP);

  // Request decode: signedness, magnitudes and divide fast paths
  logic            in_div;
  logic            in_signed_1;
  logic            in_signed_2;
  logic            in_neg_1;
  logic            in_neg_2;
  logic            div_zero;
  logic            div_ovf;
  logic            fast;
  logic [XLEN-1:0] mag_1;
  logic [XLEN-1:0] mag_2;
  logic [XLEN-1:0] fast_res;

  always_comb begin
    in_div      = funct3_i[2];
    in_signed_1 = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                  (funct3_i == 3'b100) || (funct3_i == 3'b110);
    in_signed_2 = (funct3_i == 3'b001) || (funct3_i == 3'b100) ||
                  (funct3_i == 3'b110);
    in_neg_1    = in_signed_1 && op_1_i[XLEN-1];
    in_neg_2    = in_signed_2 && op_2_i[XLEN-1];
    mag_1       = in_neg_1 ? -op_1_i : op_1_i;
    mag_2       = in_neg_2 ? -op_2_i : op_2_i;
    div_zero    = (op_2_i == '0);
    // funct3 bit 0 clear within the divide group selects the signed ops
    div_ovf     = !funct3_i[0] && (op_1_i == INT_MIN) && (op_2_i == '1);
    fast        = in_div && (div_zero || div_ovf);
    // funct3 bit 1 separates REM/REMU from DIV/DIVU
    if (div_zero) begin
      fast_res = funct3_i[1] ? op_1_i : '1;
    end else begin
      fast_res = funct3_i[1] ? '0 : op_1_i;
    end
  end

  // One iteration step
  logic [XLEN-1:0]          acc_hi;
  logic [XLEN-1:0]          acc_lo;
  logic [XLEN+MUL_STEP-1:0] mul_part;
  logic [XLEN+MUL_STEP-1:0] mul_sum;
  logic [XLEN:0]            div_shift;
  logic [XLEN:0]            div_diff;

  assign acc_hi = acc[2*XLEN-1:XLEN];
  assign acc_lo = acc[XLEN-1:0];

  always_comb begin
    mul_part = '0;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (acc_lo[i]) begin
        mul_part = mul_part + ({{MUL_STEP{1'b0}}, op_mag} << i);
      end
    end
    mul_sum   = {{MUL_STEP{1'b0}}, acc_hi} + mul_part;
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, op_mag};
  end

  // Sign correction and result selection
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_res;

  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    quo_fix  = neg_q ? -acc_lo : acc_lo;
    rem_fix  = neg_r ? -acc_hi : acc_hi;
    case (f3)
      3'b000:                 fix_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quo_fix;
      default:                fix_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      op_mag   <= '0;
      f3       <= '0;
      tag_q    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      valid_o  <= 1'b0;
      result_o <= '0;
      tag_o    <= '0;
    end else begin
      valid_o <= 1'b0;
      if (flush_i) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (accept) begin
              f3    <= funct3_i;
              tag_q <= tag_i;
              neg_q <= in_neg_1 ^ in_neg_2;
              neg_r <= in_neg_1;
              if (fast) begin
                state    <= S_DONE;
                valid_o  <= 1'b1;
                result_o <= fast_res;
                tag_o    <= tag_i;
              end else if (in_div) begin
                state  <= S_CALC;
                cnt    <= DIV_LAST;
                acc    <= {{XLEN{1'b0}}, mag_1};
                op_mag <= mag_2;
              end else begin
                state  <= S_CALC;
                cnt    <= MUL_LAST;
                acc    <= {{XLEN{1'b0}}, mag_2};
                op_mag <= mag_1;
              end
            end else begin
              state <= S_IDLE;
            end
          end
          S_CALC: begin
            if (f3[2]) begin
              // Restoring step: keep the difference only when it did not borrow
              if (!div_diff[XLEN]) begin
                acc <= {div_diff[XLEN-1:0], acc_lo[XLEN-2:0], 1'b1};
              end else begin
                acc <= {div_shift[XLEN-1:0], acc_lo[XLEN-2:0], 1'b0};
              end
            end else begin
              acc <= {mul_sum, acc_lo[XLEN-1:MUL_STEP]};
            end
            if (cnt == '0) begin
              state <= S_FIXUP;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          S_FIXUP: begin
            state    <= S_DONE;
            valid_o  <= 1'b1;
            result_o <= fix_res;
            tag_o    <= tag_q;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
